// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter, bundled as one interface.
// master = the arbiter, slave = the surrounding producers + FIFO (or a testbench).
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_wr_data;
    logic                  fifo_full;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NREQ valid/ready producers into one FIFO write port.
// A grant lasts until MAX_BURST beats have moved or the owner drops valid; the
// released producer then has lowest priority for the next arbitration.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = 4;   // burst counter, holds 0..15

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_grant_id;
    logic [IDW-1:0]  r_rr_ptr;
    logic [CW-1:0]   r_burst_cnt;

    logic            w_own;
    logic            w_owner_valid;
    logic            w_xfer;
    logic            w_last_beat;
    logic            w_any_valid;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  w_next_rr;

    // (base + offs) mod NREQ for offs in 0..NREQ-1; NREQ need not be a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    // Circular search for the first valid producer at or after r_rr_ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        w_pick      = '0;
        w_any_valid = 1'b0;
        // Walk from the farthest offset back to the nearest so the nearest valid wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_pick      = wrap_add(r_rr_ptr, k);
                w_any_valid = 1'b1;
            end
        end
    end

    // Reset gates the handshake immediately so no beat moves in the reset cycle.
    assign w_own         = (r_state == ST_OWN) && !rst;
    assign w_owner_valid = bus.req_valid[r_grant_id];
    assign w_xfer        = w_own && w_owner_valid && !bus.fifo_full;
    assign w_last_beat   = (r_burst_cnt == CW'(MAX_BURST - 1));
    assign w_next_rr     = wrap_add(r_grant_id, 1);

    // Handshake outputs: only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        bus.req_ready = '0;
        if (w_own && !bus.fifo_full) begin
            bus.req_ready[r_grant_id] = 1'b1;
        end
        bus.fifo_wr_en   = w_xfer;
        bus.fifo_wr_data = bus.req_data[r_grant_id*WIDTH +: WIDTH];
    end

    assign bus.grant_id = r_grant_id;
    assign bus.busy     = (r_state == ST_OWN);

    // IDLE/OWN state machine with grant, burst counter and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples
        // values from before the edge, independent of statement order.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_state     <= ST_OWN;
                        r_grant_id  <= w_pick;
                        r_burst_cnt <= '0;
                    end
                end
                ST_OWN: begin
                    if (!w_owner_valid) begin
                        // Owner gave up (even while the FIFO is full): release.
                        r_state     <= ST_IDLE;
                        r_rr_ptr    <= w_next_rr;
                        r_burst_cnt <= '0;
                    end else if (w_xfer) begin
                        if (w_last_beat) begin
                            r_state     <= ST_IDLE;
                            r_rr_ptr    <= w_next_rr;
                            r_burst_cnt <= '0;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + CW'(1);
                        end
                    end
                    // FIFO full with owner still valid: hold grant and count.
                end
            endcase
        end
    end
endmodule
